// File: rtl/lcd_pkg.sv
// Shared types, command constants and 50 MHz timing defaults for the LCD write engine.
// LCD_INIT_SEQ_EN adds the power-on init states to the state encoding.
package lcd_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 32;

  // One queued bus write: register select plus the byte
  typedef struct packed {
    logic              rs;
    logic [DATA_W-1:0] data;
  } lcd_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
`ifdef LCD_INIT_SEQ_EN
    , ST_INIT_PWR
    , ST_INIT_CMD
`endif
  } state_t;

  // HD44780 command bytes
  localparam logic [DATA_W-1:0] FUNCTION_SET    = 8'h38;
  localparam logic [DATA_W-1:0] ENTRY_MODE      = 8'h07;
  localparam logic [DATA_W-1:0] DISPLAY_CONTROL = 8'h0C;
  localparam logic [DATA_W-1:0] CLEAR           = 8'h01;
  localparam logic [DATA_W-1:0] HOME            = 8'h02;
  localparam logic [DATA_W-1:0] SET_DD_RAM      = 8'h80;
  localparam logic [DATA_W-1:0] SHIFT           = 8'h18;

  // Timing defaults in 50 MHz clock cycles
  localparam int unsigned DEF_SETUP_CYCLES     = 2;
  localparam int unsigned DEF_PULSE_CYCLES     = 12;
  localparam int unsigned DEF_HOLD_CYCLES      = 1;
  localparam int unsigned DEF_CMD_WAIT_CYCLES  = 2000;
  localparam int unsigned DEF_LONG_WAIT_CYCLES = 82000;
  localparam int unsigned DEF_POWER_ON_WAIT    = 750000;
  localparam int unsigned DEF_INIT_WAIT_1      = 205000;
  localparam int unsigned DEF_INIT_WAIT_2      = 5000;

  // Clear/home (and 0x03, which the controller also decodes as home) need the long wait
  function automatic logic needs_long_wait(input lcd_cmd_t c);
    return !c.rs && (c.data == CLEAR || c.data == HOME || c.data == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous FIFO of {RS, DATA} writes with registered full/empty flags.
module lcd_cmd_fifo
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  lcd_cmd_t wdata,
  output lcd_cmd_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  lcd_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset since empty gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers, occupancy count and the flags derived from it
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10: begin
          count <= count + CW'(1);
          full  <= (count == CW'(DEPTH - 1));
          empty <= 1'b0;
        end
        2'b01: begin
          count <= count - CW'(1);
          full  <= 1'b0;
          empty <= (count == CW'(1));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lcd_write_engine.sv
// HD44780 8-bit bus write engine: queues {RS, byte} requests and plays them out
// with setup / E-pulse / hold / post-command wait timing.
// Define LCD_INIT_SEQ_EN to run the power-on 0x38 x3 init sequence after reset.
module lcd_write_engine
  import lcd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter int unsigned SETUP_CYCLES     = DEF_SETUP_CYCLES,
  parameter int unsigned PULSE_CYCLES     = DEF_PULSE_CYCLES,
  parameter int unsigned HOLD_CYCLES      = DEF_HOLD_CYCLES,
  parameter int unsigned CMD_WAIT_CYCLES  = DEF_CMD_WAIT_CYCLES,
  parameter int unsigned LONG_WAIT_CYCLES = DEF_LONG_WAIT_CYCLES
`ifdef LCD_INIT_SEQ_EN
  , parameter int unsigned POWER_ON_WAIT  = DEF_POWER_ON_WAIT
  , parameter int unsigned INIT_WAIT_1    = DEF_INIT_WAIT_1
  , parameter int unsigned INIT_WAIT_2    = DEF_INIT_WAIT_2
`endif
) (
  input  logic              CLOCK_50MHZ,
  input  logic              BUTTON_SOUTH,
  input  logic              CMD_VALID,
  input  logic              CMD_RS,
  input  logic [DATA_W-1:0] CMD_DATA,
  output logic              CMD_READY,
  output logic              BUSY,
  output logic [DATA_W-1:0] LCD_DATA_BIT,
  output logic              LCD_ENABLE,
  output logic              LCD_REGISTER_SELECT,
  output logic              LCD_READ_WRITE
);

  // Counter reload values: each phase of N cycles loads N-1
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_WAIT_CYCLES - 1);
`ifdef LCD_INIT_SEQ_EN
  localparam logic [CNT_W-1:0] PWR_LD   = CNT_W'(POWER_ON_WAIT - 1);
  localparam logic [CNT_W-1:0] INIT1_LD = CNT_W'(INIT_WAIT_1 - 1);
  localparam logic [CNT_W-1:0] INIT2_LD = CNT_W'(INIT_WAIT_2 - 1);
`endif

  lcd_cmd_t         wr_cmd;
  lcd_cmd_t         head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] wait_ld;
`ifdef LCD_INIT_SEQ_EN
  logic [1:0]       init_left;
`endif

  assign wr_cmd   = '{rs: CMD_RS, data: CMD_DATA};
  assign fifo_pop = (state == ST_IDLE) && !fifo_empty;

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLOCK_50MHZ),
    .rst   (BUTTON_SOUTH),
    .push  (CMD_VALID),
    .pop   (fifo_pop),
    .wdata (wr_cmd),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign CMD_READY      = !fifo_full;
  assign BUSY           = (state != ST_IDLE) || !fifo_empty;
  assign LCD_READ_WRITE = 1'b0;

  // Bus sequencer: pop, setup, E pulse, hold, post-command wait
  always_ff @(posedge CLOCK_50MHZ) begin
    if (BUTTON_SOUTH) begin
`ifdef LCD_INIT_SEQ_EN
      state     <= ST_INIT_PWR;
      cnt       <= PWR_LD;
      init_left <= 2'd3;
`else
      state     <= ST_IDLE;
      cnt       <= '0;
`endif
      wait_ld             <= '0;
      LCD_ENABLE          <= 1'b0;
      LCD_REGISTER_SELECT <= 1'b0;
      LCD_DATA_BIT        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            LCD_REGISTER_SELECT <= head.rs;
            LCD_DATA_BIT        <= head.data;
            wait_ld             <= needs_long_wait(head) ? LONG_LD : CMD_LD;
            cnt                 <= SETUP_LD;
            state               <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            LCD_ENABLE <= 1'b1;
            cnt        <= PULSE_LD;
            state      <= ST_PULSE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            LCD_ENABLE <= 1'b0;
            cnt        <= HOLD_LD;
            state      <= ST_HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            cnt   <= wait_ld;
            state <= ST_WAIT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
`ifdef LCD_INIT_SEQ_EN
            state <= (init_left != 2'd0) ? ST_INIT_CMD : ST_IDLE;
`else
            state <= ST_IDLE;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`ifdef LCD_INIT_SEQ_EN
        ST_INIT_PWR: begin
          if (cnt == '0) begin
            state <= ST_INIT_CMD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_INIT_CMD: begin
          LCD_REGISTER_SELECT <= 1'b0;
          LCD_DATA_BIT        <= FUNCTION_SET;
          case (init_left)
            2'd3:    wait_ld <= INIT1_LD;
            2'd2:    wait_ld <= INIT2_LD;
            default: wait_ld <= CMD_LD;
          endcase
          init_left <= init_left - 2'd1;
          cnt       <= SETUP_LD;
          state     <= ST_SETUP;
        end
`endif
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_engine.sv
// Scoreboard bench for lcd_write_engine: expected bus writes are queued as they
// are pushed and compared on every E rising edge, along with timing checks.
module tb_lcd_write_engine;
  import lcd_pkg::*;

  localparam int S    = 2;
  localparam int P    = 12;
  localparam int H    = 1;
  localparam int CW   = 200;
  localparam int LW   = 900;
  localparam int BASE = 1 + S + P + H;
`ifdef LCD_INIT_SEQ_EN
  localparam int PW   = 3000;
  localparam int W1   = 800;
  localparam int W2   = 300;
`endif

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         gap;      // expected cycles since previous E rise, 0 = unchecked
    int         rise_at;  // expected cycle of E rise, -1 = unchecked
  } exp_t;

  logic       clk = 1'b0;
  logic       btn;
  logic       cmd_valid;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       busy;
  logic [7:0] lcd_db;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;

  exp_t sb[$];
  exp_t cur;
  bit   have_cur = 0;
  bit   e_prev = 0;
  bit   abort = 0;
  int   cyc = 0;
  int   rises = 0;
  int   last_rise = 0;
  int   hi_cnt = 0;
  int   total = 0;
  int   bad = 0;

  lcd_write_engine #(
    .FIFO_DEPTH       (4),
    .SETUP_CYCLES     (S),
    .PULSE_CYCLES     (P),
    .HOLD_CYCLES      (H),
    .CMD_WAIT_CYCLES  (CW),
    .LONG_WAIT_CYCLES (LW)
`ifdef LCD_INIT_SEQ_EN
    , .POWER_ON_WAIT  (PW)
    , .INIT_WAIT_1    (W1)
    , .INIT_WAIT_2    (W2)
`endif
  ) dut (
    .CLOCK_50MHZ         (clk),
    .BUTTON_SOUTH        (btn),
    .CMD_VALID           (cmd_valid),
    .CMD_RS              (cmd_rs),
    .CMD_DATA            (cmd_data),
    .CMD_READY           (cmd_ready),
    .BUSY                (busy),
    .LCD_DATA_BIT        (lcd_db),
    .LCD_ENABLE          (lcd_e),
    .LCD_REGISTER_SELECT (lcd_rs),
    .LCD_READ_WRITE      (lcd_rw)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference wait length for a write
  function automatic int wt(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? LW : CW;
  endfunction

  // Bus monitor: R/W level, pulse contents, latency, spacing and width
  always @(negedge clk) begin
    check_eq("rw_low", 32'(lcd_rw), 32'd0);
    if (lcd_e && !e_prev) begin
      rises++;
      check_eq("pulse_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        cur = sb.pop_front();
        have_cur = 1;
        check_eq("rise_rs", 32'(lcd_rs), 32'(cur.rs));
        check_eq("rise_data", 32'(lcd_db), 32'(cur.data));
        if (cur.gap > 0) check_eq("rise_gap", 32'(cyc - last_rise), 32'(cur.gap));
        if (cur.rise_at >= 0) check_eq("rise_latency", 32'(cyc), 32'(cur.rise_at));
      end
      last_rise = cyc;
      hi_cnt = 1;
    end else if (lcd_e) begin
      hi_cnt++;
      if (have_cur) check_eq("pulse_bus", 32'({lcd_rs, lcd_db}), 32'({cur.rs, cur.data}));
    end
    if (!lcd_e && e_prev && !abort) begin
      check_eq("pulse_width", 32'(hi_cnt), 32'(P));
      if (have_cur) check_eq("hold_bus", 32'({lcd_rs, lcd_db}), 32'({cur.rs, cur.data}));
    end
    e_prev = lcd_e;
  end

  // Present one request at a negedge, hold until accepted, queue its expectation
  task automatic push(input logic rs, input logic [7:0] d, input int gap, input bit lat);
    int n = 0;
    exp_t x;
    cmd_valid = 1'b1;
    cmd_rs    = rs;
    cmd_data  = d;
    while (!cmd_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check_eq("push_ready", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    x.rs      = rs;
    x.data    = d;
    x.gap     = gap;
    x.rise_at = lat ? (cyc + 2 + S) : -1;
    sb.push_back(x);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_eq({"idle_", tag}, 32'(busy), 32'd0);
  endtask

  task automatic wait_rise(input int r0, input int bound);
    int n = 0;
    while (rises == r0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_eq("rise_seen", 32'(rises > r0), 32'd1);
  endtask

  logic [8:0] wsel [8] = '{9'h001, 9'h018, 9'h101, 9'h003, 9'h004, 9'h000, 9'h002, 9'h144};

  initial begin
    int r0;
    int r_at;
    int rst_cyc;
    btn       = 1'b1;
    cmd_valid = 1'b0;
    cmd_rs    = 1'b0;
    cmd_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_e", 32'(lcd_e), 32'd0);
    check_eq("rst_rs", 32'(lcd_rs), 32'd0);
    check_eq("rst_db", 32'(lcd_db), 32'd0);
    check_eq("rst_ready", 32'(cmd_ready), 32'd1);
`ifdef LCD_INIT_SEQ_EN
    check_eq("rst_busy", 32'(busy), 32'd1);
`else
    check_eq("rst_busy", 32'(busy), 32'd0);
`endif
    rst_cyc = cyc;
    btn = 1'b0;

`ifdef LCD_INIT_SEQ_EN
    // Power-on sequence, then a user byte pushed early comes out last
    sb.push_back('{1'b0, FUNCTION_SET, 0, rst_cyc + PW + 1 + S});
    sb.push_back('{1'b0, FUNCTION_SET, BASE + W1, -1});
    sb.push_back('{1'b0, FUNCTION_SET, BASE + W2, -1});
    repeat (10) @(negedge clk);
    check_eq("init_busy", 32'(busy), 32'd1);
    push(1'b1, 8'h55, BASE + CW, 1'b0);
    cmd_valid = 1'b0;
    check_eq("init_ready", 32'(cmd_ready), 32'd1);
    repeat (100) @(negedge clk);
    check_eq("init_busy_mid", 32'(busy), 32'd1);
    wait_idle("init", PW + W1 + W2 + 2 * CW + 500);
    check_eq("init_rises", 32'(rises), 32'd4);
`else
    // Single data write: latency, width, busy duration, bus persistence
    push(1'b1, 8'h44, 0, 1'b1);
    cmd_valid = 1'b0;
    check_eq("busy_after_push", 32'(busy), 32'd1);
    wait_idle("single", 5000);
    r_at = last_rise;
    check_eq("busy_drop", 32'(cyc - (r_at - S)), 32'(S + P + H + CW));
    check_eq("bus_persist", 32'({lcd_rs, lcd_db}), 32'h144);

    // Wait selection across clear/home boundaries, back to back
    for (int i = 0; i < 8; i++) begin
      int g;
      g = 0;
      if (i > 0) g = BASE + wt(wsel[i-1][8], wsel[i-1][7:0]);
      push(wsel[i][8], wsel[i][7:0], g, 1'b0);
    end
    cmd_valid = 1'b0;
    wait_idle("wsel", 20000);

    // Burst of 6 behind a running command: FIFO fills after 4
    r0 = rises;
    push(1'b1, 8'h41, 0, 1'b0);
    cmd_valid = 1'b0;
    wait_rise(r0, 100);
    for (int i = 0; i < 6; i++) begin
      push(1'b1, 8'(8'h42 + i), BASE + CW, 1'b0);
      if (i == 2) check_eq("ready_not_full", 32'(cmd_ready), 32'd1);
      if (i == 3) check_eq("ready_full", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    wait_idle("burst", 20000);

    // Reset in the middle of an E pulse with three writes queued
    r0 = rises;
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 8'(8'h10 + i), (i == 0) ? 0 : BASE + CW, 1'b0);
    end
    cmd_valid = 1'b0;
    wait_rise(r0, 100);
    repeat (5) @(negedge clk);
    check_eq("mid_pulse_e", 32'(lcd_e), 32'd1);
    abort = 1;
    btn   = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    check_eq("rst_pulse_e", 32'(lcd_e), 32'd0);
    check_eq("rst_pulse_db", 32'(lcd_db), 32'd0);
    check_eq("rst_pulse_rs", 32'(lcd_rs), 32'd0);
    check_eq("rst_pulse_busy", 32'(busy), 32'd0);
    check_eq("rst_pulse_ready", 32'(cmd_ready), 32'd1);
    sb.delete();
    r0 = rises;
    repeat (2 * (BASE + LW)) @(negedge clk);
    check_eq("no_pulse_after_rst", 32'(rises), 32'(r0));
    abort = 0;

    // Engine still works after the mid-pulse reset
    push(1'b0, SET_DD_RAM, 0, 1'b1);
    cmd_valid = 1'b0;
    wait_idle("post_rst", 5000);
    check_eq("post_rst_bus", 32'({lcd_rs, lcd_db}), 32'h080);
`endif

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
